// File: rtl/svv_spi3w_pkg.sv
// Shared definitions for the 3-wire SPI target.
// Frame layout, MSB first: bit 23 R/W (1 = read), bits 22:8 address, bits 7:0 data.
// Contents: frame geometry constants, the frame-state enum and an address-range helper.
package svv_spi3w_pkg;

    localparam int FRAME_BITS = 24;
    localparam int HDR_BITS   = 16;
    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 8;
    localparam int RW_BIT     = 23;
    localparam int CNT_W      = 5;

    typedef enum logic [2:0] {
        LOCKOUT,
        IDLE,
        HDR,
        WRD,
        RD,
        DONE
    } state_t;

    // True when addr falls inside a register file of 2**aw entries.
    function automatic logic addr_in_file(input logic [ADDR_W-1:0] addr, input int aw);
        return (addr >> aw) == '0;
    endfunction

endpackage

// File: rtl/svv_spi3w_sync.sv
// Multi-stage synchronizer for one asynchronous input, plus a history flop
// that turns the synchronized level into single-cycle rise/fall pulses.
// Ports:
//   clk    : sampling clock
//   resetn : synchronous active-low reset
//   din    : asynchronous input
//   q      : synchronized level
//   rise   : one-cycle pulse on a synchronized 0->1 transition
//   fall   : one-cycle pulse on a synchronized 1->0 transition
module svv_spi3w_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_reg;
    logic              hist_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain_reg <= {STAGES{RESET_VAL}};
            hist_reg  <= RESET_VAL;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], din};
            hist_reg  <= chain_reg[STAGES-1];
        end
    end

    assign q    = chain_reg[STAGES-1];
    assign rise = q & ~hist_reg;
    assign fall = ~q & hist_reg;

endmodule

// File: rtl/svv_spi3w_target.sv
// 3-wire SPI target: oversamples SCLK/nCS/SDIO on slmb_aclk, decodes 24-bit
// frames, commits writes into a small register file and drives read data
// back on the shared SDIO line.
// Ports:
//   slmb_aclk, slmb_aresetn : clock, synchronous active-low reset
//   SCLK, nCS               : asynchronous SPI clock / chip select from the master
//   sdio_i, sdio_o, sdio_t  : SDIO pad buffer (sdio_t = 1 releases the line)
//   wr_stb, wr_addr, wr_data: one-cycle commit pulse with address and data
//   reg_addr, reg_data      : host-side register read, one cycle latency
//   abort_cnt               : saturating count of frames cut short by nCS
module svv_spi3w_target
    import svv_spi3w_pkg::*;
#(
    parameter int          REG_AW      = 5,
    parameter logic [7:0]  ID_VALUE    = 8'hA5,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              slmb_aclk,
    input  logic              slmb_aresetn,
    input  logic              SCLK,
    input  logic              nCS,
    input  logic              sdio_i,
    output logic              sdio_o,
    output logic              sdio_t,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_data,
    output logic [7:0]        abort_cnt
);

    localparam int REGS = 2 ** REG_AW;
    localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

    // ---------------------------------------------------------------- inputs
    logic sclk_q_unused, sclk_rise, sclk_fall;
    logic ncs_q, ncs_rise, ncs_fall;

    svv_spi3w_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk    (slmb_aclk),
        .resetn (slmb_aresetn),
        .din    (SCLK),
        .q      (sclk_q_unused),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    // nCS resets to "asserted" so that a real high level must be seen before
    // the lockout is released; otherwise a frame already in flight at reset
    // would look like a fresh falling edge.
    svv_spi3w_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ncs_sync (
        .clk    (slmb_aclk),
        .resetn (slmb_aresetn),
        .din    (nCS),
        .q      (ncs_q),
        .rise   (ncs_rise),
        .fall   (ncs_fall)
    );

    // SDIO only needs the level, aligned with the SCLK pulses.
    logic [SYNC_STAGES-1:0] sdio_chain_reg;
    logic                   sdio_q;

    always_ff @(posedge slmb_aclk) begin
        if (!slmb_aresetn) begin
            sdio_chain_reg <= '0;
        end else begin
            sdio_chain_reg <= {sdio_chain_reg[SYNC_STAGES-2:0], sdio_i};
        end
    end

    assign sdio_q = sdio_chain_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------- datapath
    state_t              state_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [ADDR_W-1:0]   shift_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   rd_shift_reg;
    logic                sdio_o_reg;
    logic                sdio_t_reg;
    logic                wr_stb_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [DATA_W-1:0]   wr_data_reg;
    logic [DATA_W-1:0]   reg_data_reg;
    logic [7:0]          abort_cnt_reg;
    logic [DATA_W-1:0]   regfile [REGS];

    logic [ADDR_W-1:0]   shift_in;
    logic                hdr_rw;
    logic [ADDR_W-1:0]   hdr_addr;
    logic [DATA_W-1:0]   rd_lookup;
    logic                last_rise;
    logic                in_frame;
    logic                abort;
    logic                commit_to_file;

    // With 15 bits already shifted, the incoming bit completes the header:
    // the oldest bit is R/W and the rest plus the new bit form the address.
    assign shift_in = {shift_reg[ADDR_W-2:0], sdio_q};
    assign hdr_rw   = shift_reg[ADDR_W-1];
    assign hdr_addr = shift_in;

    always_comb begin
        rd_lookup = '0;
        if (hdr_addr == '0) begin
            rd_lookup = ID_VALUE;
        end else if (addr_in_file(hdr_addr, REG_AW)) begin
            rd_lookup = regfile[hdr_addr[REG_AW-1:0]];
        end
    end

    // The 24th rise wins over a coincident nCS rise: the frame completes.
    assign last_rise      = sclk_rise && (bit_cnt_reg == FRAME_LAST);
    assign in_frame       = (state_reg == HDR) || (state_reg == WRD) || (state_reg == RD);
    assign abort          = ncs_rise && in_frame && !(last_rise && (state_reg != HDR));
    assign commit_to_file = (addr_reg != '0) && addr_in_file(addr_reg, REG_AW);

    always_ff @(posedge slmb_aclk) begin
        if (!slmb_aresetn) begin
            state_reg     <= LOCKOUT;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            addr_reg      <= '0;
            rd_shift_reg  <= '0;
            sdio_o_reg    <= 1'b0;
            sdio_t_reg    <= 1'b1;
            wr_stb_reg    <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            abort_cnt_reg <= '0;
            for (int i = 0; i < REGS; i++) begin
                regfile[i] <= '0;
            end
        end else begin
            wr_stb_reg <= 1'b0;
            if (abort) begin
                sdio_t_reg <= 1'b1;
                state_reg  <= IDLE;
                if (abort_cnt_reg != 8'hFF) begin
                    abort_cnt_reg <= abort_cnt_reg + 8'd1;
                end
            end else begin
                case (state_reg)
                    LOCKOUT: begin
                        if (ncs_q) begin
                            state_reg <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (ncs_fall) begin
                            bit_cnt_reg <= '0;
                            shift_reg   <= '0;
                            state_reg   <= HDR;
                        end
                    end
                    HDR: begin
                        if (sclk_rise) begin
                            shift_reg   <= shift_in;
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            if (bit_cnt_reg == HDR_LAST) begin
                                addr_reg <= hdr_addr;
                                if (hdr_rw) begin
                                    rd_shift_reg <= rd_lookup;
                                    state_reg    <= RD;
                                end else begin
                                    state_reg <= WRD;
                                end
                            end
                        end
                    end
                    WRD: begin
                        if (sclk_rise) begin
                            shift_reg   <= shift_in;
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            if (last_rise) begin
                                wr_stb_reg  <= 1'b1;
                                wr_addr_reg <= addr_reg;
                                wr_data_reg <= shift_in[DATA_W-1:0];
                                if (commit_to_file) begin
                                    regfile[addr_reg[REG_AW-1:0]] <= shift_in[DATA_W-1:0];
                                end
                                // nCS already gone: no further rise will arrive for DONE.
                                state_reg <= ncs_rise ? IDLE : DONE;
                            end
                        end
                    end
                    RD: begin
                        if (sclk_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            if (last_rise) begin
                                state_reg <= ncs_rise ? IDLE : DONE;
                                if (ncs_rise) begin
                                    sdio_t_reg <= 1'b1;
                                end
                            end
                        end else if (sclk_fall) begin
                            sdio_t_reg   <= 1'b0;
                            sdio_o_reg   <= rd_shift_reg[DATA_W-1];
                            rd_shift_reg <= {rd_shift_reg[DATA_W-2:0], 1'b0};
                        end
                    end
                    DONE: begin
                        if (ncs_rise) begin
                            sdio_t_reg <= 1'b1;
                            state_reg  <= IDLE;
                        end
                    end
                    default: state_reg <= LOCKOUT;
                endcase
            end
        end
    end

    // Host read port, registered every cycle.
    always_ff @(posedge slmb_aclk) begin
        if (!slmb_aresetn) begin
            reg_data_reg <= '0;
        end else begin
            reg_data_reg <= (reg_addr == '0) ? ID_VALUE : regfile[reg_addr];
        end
    end

    assign sdio_o    = sdio_o_reg;
    assign sdio_t    = sdio_t_reg;
    assign wr_stb    = wr_stb_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign reg_data  = reg_data_reg;
    assign abort_cnt = abort_cnt_reg;

endmodule
